// File: rtl/gen_emu_clks_pkg.sv
// Shared types and default sizes for the emulation clock generator and its channels.
package gen_emu_clks_pkg;

    typedef enum logic {
        CH_MODE_EXT = 1'b0,
        CH_MODE_DIV = 1'b1
    } ch_mode_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STALLED = 1'b1
    } state_t;

    localparam int N_DEF     = 2;
    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/emu_clk_div_ch.sv
// One derived clock channel: shadowed mode/ratio, divide counter, EXT/DIV select and enable gating.
// The output register only moves on update edges so it stays aligned with emu_clk rising.
module emu_clk_div_ch
    import gen_emu_clks_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_load_i,
    input  ch_mode_t         mode_i,
    input  logic [DIV_W-1:0] ratio_i,
    input  logic             en_i,
    input  logic             ext_val_i,
    input  logic             update_i,
    input  logic             restart_i,
    output logic             clk_o
);

    localparam logic [DIV_W-1:0] SENTINEL  = '1;
    localparam logic [DIV_W-1:0] RATIO_ONE = DIV_W'(1);

    ch_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    always_comb begin
        mode_d  = mode_q;
        ratio_d = ratio_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        if (cfg_load_i) begin
            mode_d  = mode_i;
            ratio_d = ratio_i;
        end
        if (update_i) begin
            if (!en_i) begin
                clk_d = 1'b0;
                cnt_d = SENTINEL;
            end else if (mode_q == CH_MODE_EXT) begin
                clk_d = ext_val_i;
                cnt_d = SENTINEL;
            end else if (ratio_q <= RATIO_ONE) begin
                clk_d = 1'b0;
                cnt_d = SENTINEL;
            end else if (restart_i) begin
                cnt_d = '0;
                clk_d = 1'b1;
            end else begin
                // Sentinel is >= R-1, so a parked counter always restarts at 0 (high phase).
                cnt_d = (cnt_q >= ratio_q - RATIO_ONE) ? '0 : cnt_q + RATIO_ONE;
                clk_d = (cnt_d < (ratio_q >> 1));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= CH_MODE_EXT;
            ratio_q <= '0;
            cnt_q   <= SENTINEL;
            clk_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
        end
    end

    assign clk_o = clk_q;

endmodule

// File: rtl/gen_emu_clks_div.sv
// Emulation clock generator: emu_clk = emu_clk_2x/2 with stall handshake, plus N derived channel clocks.
// Define GEN_EMU_CLKS_DIV_BUFG_EN to route emu_clk and clks through BUFG primitives.
module gen_emu_clks_div
    import gen_emu_clks_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               emu_clk_2x,
    input  logic               emu_rst_n,
    output logic               emu_clk,
    output logic [N-1:0]       clks,
    input  logic [N-1:0]       clk_vals,
    input  logic [N-1:0]       ch_en,
    input  logic [N-1:0]       ch_mode,
    input  logic [N*DIV_W-1:0] div_ratio,
    input  logic               cfg_load,
    input  logic               stall_req,
    output logic               stall_ack,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             emu_clk_q, emu_clk_d;
    logic             stall_ack_q, stall_ack_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             update;
    logic [N-1:0]     ch_clk;

    always_comb begin
        state_d     = state_q;
        emu_clk_d   = emu_clk_q;
        stall_ack_d = stall_ack_q;
        cyc_d       = cyc_q;
        update      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!emu_clk_q) begin
                    update    = 1'b1;
                    emu_clk_d = 1'b1;
                    cyc_d     = cyc_q + CNT_ONE;
                end else begin
                    emu_clk_d = 1'b0;
                    if (stall_req) begin
                        stall_ack_d = 1'b1;
                        state_d     = ST_STALLED;
                    end
                end
            end
            ST_STALLED: begin
                emu_clk_d = 1'b0;
                if (!stall_req) begin
                    stall_ack_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // A load coinciding with an update edge stays pending for the following one.
        pend_d = cfg_load ? 1'b1 : (update ? 1'b0 : pend_q);
    end

    always_ff @(posedge emu_clk_2x or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q     <= ST_RUN;
            emu_clk_q   <= 1'b0;
            stall_ack_q <= 1'b0;
            pend_q      <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            emu_clk_q   <= emu_clk_d;
            stall_ack_q <= stall_ack_d;
            pend_q      <= pend_d;
            cyc_q       <= cyc_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        emu_clk_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_i     (emu_clk_2x),
            .rst_ni    (emu_rst_n),
            .cfg_load_i(cfg_load),
            .mode_i    (ch_mode_t'(ch_mode[gi])),
            .ratio_i   (div_ratio[gi*DIV_W +: DIV_W]),
            .en_i      (ch_en[gi]),
            .ext_val_i (clk_vals[gi]),
            .update_i  (update),
            .restart_i (pend_q),
            .clk_o     (ch_clk[gi])
        );
`ifdef GEN_EMU_CLKS_DIV_BUFG_EN
        BUFG u_bufg_ch (.I(ch_clk[gi]), .O(clks[gi]));
`else
        assign clks[gi] = ch_clk[gi];
`endif
    end

`ifdef GEN_EMU_CLKS_DIV_BUFG_EN
    BUFG u_bufg_emu (.I(emu_clk_q), .O(emu_clk));
`else
    assign emu_clk = emu_clk_q;
`endif

    assign stall_ack = stall_ack_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_gen_emu_clks_div.sv
// Self-checking bench for gen_emu_clks_div: directed scenarios plus randomized traffic against a behavioural model.
module tb_gen_emu_clks_div;

    localparam int N     = 2;
    localparam int DIV_W = 8;

    logic             emu_clk_2x = 1'b0;
    logic             emu_rst_n  = 1'b0;
    logic [N-1:0]     clk_vals   = '0;
    logic [N-1:0]     ch_en      = '0;
    logic [N-1:0]     ch_mode    = '0;
    logic [N*DIV_W-1:0] div_ratio = '0;
    logic             cfg_load   = 1'b0;
    logic             stall_req  = 1'b0;

    logic             emu_clk, emu_clk4;
    logic [N-1:0]     clks, clks4;
    logic             stall_ack, stall_ack4;
    logic [31:0]      cycle_cnt;
    logic [3:0]       cycle_cnt4;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 emu_clk_2x = ~emu_clk_2x;

    gen_emu_clks_div #(.N(N), .DIV_W(DIV_W), .CNT_W(32)) dut (
        .emu_clk_2x(emu_clk_2x), .emu_rst_n(emu_rst_n), .emu_clk(emu_clk), .clks(clks),
        .clk_vals(clk_vals), .ch_en(ch_en), .ch_mode(ch_mode), .div_ratio(div_ratio),
        .cfg_load(cfg_load), .stall_req(stall_req), .stall_ack(stall_ack), .cycle_cnt(cycle_cnt)
    );

    gen_emu_clks_div #(.N(N), .DIV_W(DIV_W), .CNT_W(4)) dut4 (
        .emu_clk_2x(emu_clk_2x), .emu_rst_n(emu_rst_n), .emu_clk(emu_clk4), .clks(clks4),
        .clk_vals(clk_vals), .ch_en(ch_en), .ch_mode(ch_mode), .div_ratio(div_ratio),
        .cfg_load(cfg_load), .stall_req(stall_req), .stall_ack(stall_ack4), .cycle_cnt(cycle_cnt4)
    );

    // Behavioural model: DIV channels tracked as a phase count since (re)start, output = phase mod R in low half.
    bit          m_emu, m_stalled, m_ack, m_pend, m_upd;
    logic [31:0] m_cyc;
    logic [N-1:0] m_clks;
    bit          m_sh_div [N];
    int          m_sh_ratio [N];
    int          m_ph [N];

    task automatic model_reset();
        m_emu = 0; m_stalled = 0; m_ack = 0; m_pend = 0; m_upd = 0;
        m_cyc = '0; m_clks = '0;
        for (int k = 0; k < N; k++) begin
            m_sh_div[k] = 0; m_sh_ratio[k] = 0; m_ph[k] = -1;
        end
    endtask

    task automatic model_step();
        int r;
        m_upd = !m_stalled && !m_emu;
        if (m_stalled) begin
            if (!stall_req) begin
                m_stalled = 0; m_ack = 0;
            end
        end else if (!m_emu) begin
            m_emu = 1;
            m_cyc = m_cyc + 1;
            for (int k = 0; k < N; k++) begin
                r = m_sh_ratio[k];
                if (!ch_en[k] || !m_sh_div[k] || r < 2) begin
                    m_clks[k] = (ch_en[k] && !m_sh_div[k]) ? clk_vals[k] : 1'b0;
                    m_ph[k] = -1;
                end else begin
                    m_ph[k] = m_pend ? 0 : m_ph[k] + 1;
                    m_clks[k] = ((m_ph[k] % r) < (r / 2));
                end
            end
            m_pend = 0;
        end else begin
            m_emu = 0;
            if (stall_req) begin
                m_stalled = 1; m_ack = 1;
            end
        end
        if (cfg_load) begin
            for (int k = 0; k < N; k++) begin
                m_sh_div[k]   = ch_mode[k];
                m_sh_ratio[k] = int'(div_ratio[k*DIV_W +: DIV_W]);
            end
            m_pend = 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus the alignment rule for clks changes.
    logic [N-1:0] prev_clks;
    logic         prev_emu;
    bit           prev_valid = 0;
    always @(negedge emu_clk_2x) begin
        if (chk_en) begin
            check("emu_clk", 64'(emu_clk), 64'(m_emu));
            check("clks", 64'(clks), 64'(m_clks));
            check("stall_ack", 64'(stall_ack), 64'(m_ack));
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            check("cycle_cnt4", 64'(cycle_cnt4), 64'(m_cyc[3:0]));
            check("clks4", 64'(clks4), 64'(m_clks));
            if (prev_valid && emu_rst_n && clks !== prev_clks)
                check("clks_align", 64'({prev_emu, emu_clk}), 64'(2'b01));
            prev_valid = emu_rst_n;
            prev_clks  = clks;
            prev_emu   = emu_clk;
        end
    end

    task automatic cyc();
        @(posedge emu_clk_2x);
        if (emu_rst_n) model_step();
        else m_upd = 0;
        @(negedge emu_clk_2x);
        #1;
    endtask

    task automatic next_update(input string name, output logic v);
        bit got = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (m_upd) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no update edge within 30 cycles", name);
        end
        v = clks[1];
    endtask

    task automatic pattern(input string name, input int n, input logic [15:0] exp);
        logic [15:0] got = '0;
        logic        v;
        for (int i = 0; i < n; i++) begin
            next_update(name, v);
            got = {got[14:0], v};
        end
        check(name, 64'(got), 64'(exp));
    endtask

    task automatic load_r1(input int r);
        div_ratio[DIV_W +: DIV_W] = DIV_W'(r);
        cfg_load = 1;
        cyc();
        cfg_load = 0;
    endtask

    initial begin
        logic        v;
        logic [31:0] snap_cyc;
        logic [N-1:0] snap_clks;
        model_reset();
        repeat (2) cyc();
        chk_en = 1;
        check("rst_emu_clk", 64'(emu_clk), 0);
        check("rst_clks", 64'(clks), 0);
        check("rst_stall_ack", 64'(stall_ack), 0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 0);

        // EXT channel 0 following a toggling external value
        ch_en = 2'b01;
        clk_vals = 2'b01;
        emu_rst_n = 1;
        cyc();
        check("first_edge_emu_clk", 64'(emu_clk), 1);
        check("first_edge_cycle_cnt", 64'(cycle_cnt), 1);
        check("ext_first", 64'(clks[0]), 1);
        for (int i = 0; i < 12; i++) begin
            clk_vals[0] = ~clk_vals[0];
            cyc();
        end

        // DIV channel 1 ratios
        ch_en = 2'b11;
        ch_mode = 2'b10;
        load_r1(4);
        pattern("div_r4", 8, 16'b11001100);
        load_r1(3);
        pattern("div_r3", 6, 16'b100100);
        load_r1(1);
        pattern("div_r1", 4, 16'b0000);

        // Enable gating
        load_r1(4);
        pattern("en_pre", 2, 16'b11);
        ch_en[1] = 0;
        next_update("dis_next", v);
        check("dis_next", 64'(v), 0);
        pattern("dis_hold", 3, 16'b000);
        ch_en[1] = 1;
        next_update("reen_first", v);
        check("reen_first", 64'(v), 1);

        // Stall requested while emu_clk low
        for (int i = 0; i < 4 && m_emu; i++) cyc();
        stall_req = 1;
        cyc();
        check("stall_rise", 64'(emu_clk), 1);
        check("stall_ack_early", 64'(stall_ack), 0);
        cyc();
        check("stall_fall", 64'(emu_clk), 0);
        check("stall_ack", 64'(stall_ack), 1);
        snap_cyc = m_cyc;
        snap_clks = m_clks;
        repeat (10) cyc();
        check("stall_cnt_frozen", 64'(cycle_cnt), 64'(snap_cyc));
        check("stall_clks_frozen", 64'(clks), 64'(snap_clks));
        stall_req = 0;
        cyc();
        check("resume_low", 64'(emu_clk), 0);
        check("resume_ack", 64'(stall_ack), 0);
        cyc();
        check("resume_rise", 64'(emu_clk), 1);

        // Stall and config load on the same edge: load applies after resume
        stall_req = 1;
        cfg_load = 1;
        div_ratio[DIV_W +: DIV_W] = 8'd3;
        cyc();
        cfg_load = 0;
        check("stall_cfg_ack", 64'(stall_ack), 1);
        repeat (3) cyc();
        stall_req = 0;
        cyc();
        pattern("stall_cfg_r3", 3, 16'b100);

        // Async reset during a stall with clks[1] high
        load_r1(4);
        next_update("pre_rst", v);
        stall_req = 1;
        cyc();
        check("pre_rst_clks1", 64'(clks[1]), 1);
        check("pre_rst_ack", 64'(stall_ack), 1);
        #1;
        emu_rst_n = 0;
        model_reset();
        #1;
        check("arst_emu_clk", 64'(emu_clk), 0);
        check("arst_clks", 64'(clks), 0);
        check("arst_ack", 64'(stall_ack), 0);
        check("arst_cycle_cnt", 64'(cycle_cnt), 0);
        check("arst_cycle_cnt4", 64'(cycle_cnt4), 0);
        stall_req = 0;
        @(negedge emu_clk_2x);
        #1;
        cyc();
        emu_rst_n = 1;
        cyc();
        check("rst_release_run", 64'(emu_clk), 1);
        for (int i = 0; i < 100 && m_cyc < 17; i++) cyc();
        check("cnt4_wrap", 64'(cycle_cnt4), 1);
        check("cnt32_17", 64'(cycle_cnt), 17);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (stall_req) stall_req = ($urandom_range(0, 3) != 0);
            else           stall_req = ($urandom_range(0, 19) == 0);
            cfg_load = ($urandom_range(0, 15) == 0);
            if (cfg_load) begin
                ch_mode = N'($urandom);
                for (int k = 0; k < N; k++)
                    div_ratio[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 19) == 0) ch_en = N'($urandom);
            clk_vals = N'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
